// File: rtl/tmds_decoder.sv
// TMDS channel decoder: bit-slip word alignment from control-token runs, then 10b->8b decode.
// Optional `TMDS_DEC_SLIP_STATS_EN adds slip_count and lock_lost status outputs.
module tmds_decoder #(
   parameter int LOCK_COUNT = 8,
   parameter int SEARCH_LEN = 4096
) (
   input  logic       pixclk,
   input  logic       reset,
   input  logic [9:0] raw_in,
   input  logic       resync,
   output logic [7:0] data,
   output logic [1:0] ctrl,
   output logic       DE,
   output logic       locked,
   output logic [3:0] offset
`ifdef TMDS_DEC_SLIP_STATS_EN
   ,
   output logic [15:0] slip_count,
   output logic        lock_lost
`endif
);

   localparam logic [7:0]  LOCK_MAX    = 8'(LOCK_COUNT);
   localparam logic [15:0] SEARCH_LAST = 16'(SEARCH_LEN - 1);

   typedef enum logic {SEARCH, LOCKED} state_t;

   // {is_token, ctrl value}; data words return 3'b000
   function automatic logic [2:0] classify(input logic [9:0] w);
      logic [2:0] c;
      case (w)
         10'b1101010100: c = 3'b100;
         10'b0010101011: c = 3'b101;
         10'b0101010100: c = 3'b110;
         10'b1010101011: c = 3'b111;
         default:        c = 3'b000;
      endcase
      return c;
   endfunction

   function automatic logic [7:0] decode_word(input logic [9:0] q);
      logic [7:0] d;
      logic [7:0] r;
      d    = q[9] ? ~q[7:0] : q[7:0];
      r[0] = d[0];
      for (int i = 1; i < 8; i++)
         r[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      return r;
   endfunction

   function automatic logic [3:0] next_offset(input logic [3:0] o);
      return (o == 4'd9) ? 4'd0 : o + 4'd1;
   endfunction

   logic [9:0]  raw_prev;
   logic [19:0] cat;
   logic [9:0]  word_p0;
   logic [2:0]  class_p0;
   logic [9:0]  word_p1;
   logic [2:0]  class_p1;
   logic [7:0]  token_run;
   logic [15:0] search_cnt;
   state_t      state;

   // Stage 0: bit-slip select and token classification
   assign cat      = {raw_in, raw_prev};
   assign word_p0  = cat[{1'b0, offset} +: 10];
   assign class_p0 = classify(word_p0);

   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         raw_prev <= '0;
         word_p1  <= '0;
         class_p1 <= '0;
         data     <= '0;
         ctrl     <= '0;
         DE       <= 1'b0;
      end else begin
         raw_prev <= raw_in;
         // Stage 1: aligned word and its classification
         word_p1  <= word_p0;
         class_p1 <= class_p0;
         // Stage 2: output registers, gated by lock status
         if (!locked) begin
            data <= '0;
            ctrl <= '0;
            DE   <= 1'b0;
         end else if (class_p1[2]) begin
            data <= '0;
            ctrl <= class_p1[1:0];
            DE   <= 1'b0;
         end else begin
            data <= decode_word(word_p1);
            DE   <= 1'b1;
         end
      end
   end

   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         state      <= SEARCH;
         locked     <= 1'b0;
         offset     <= '0;
         token_run  <= '0;
         search_cnt <= '0;
`ifdef TMDS_DEC_SLIP_STATS_EN
         slip_count <= '0;
         lock_lost  <= 1'b0;
`endif
      end else begin
`ifdef TMDS_DEC_SLIP_STATS_EN
         lock_lost <= 1'b0;
`endif
         if (resync) begin
            state      <= SEARCH;
            locked     <= 1'b0;
            token_run  <= '0;
            search_cnt <= '0;
         end else begin
            token_run  <= class_p0[2] ? ((token_run == LOCK_MAX) ? LOCK_MAX : token_run + 8'd1) : 8'd0;
            search_cnt <= search_cnt + 16'd1;
            if (state == SEARCH) begin
               if (token_run == LOCK_MAX) begin
                  state      <= LOCKED;
                  locked     <= 1'b1;
                  search_cnt <= '0;
               end else if (search_cnt == SEARCH_LAST) begin
                  offset     <= next_offset(offset);
                  token_run  <= '0;
                  search_cnt <= '0;
`ifdef TMDS_DEC_SLIP_STATS_EN
                  if (slip_count != 16'hFFFF) slip_count <= slip_count + 16'd1;
`endif
               end
            end else begin
               // Every full blanking run re-qualifies the lock
               if (token_run == LOCK_MAX) begin
                  search_cnt <= '0;
               end else if (search_cnt == SEARCH_LAST) begin
                  state      <= SEARCH;
                  locked     <= 1'b0;
                  offset     <= next_offset(offset);
                  token_run  <= '0;
                  search_cnt <= '0;
`ifdef TMDS_DEC_SLIP_STATS_EN
                  lock_lost  <= 1'b1;
                  if (slip_count != 16'hFFFF) slip_count <= slip_count + 16'd1;
`endif
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed testbench for tmds_decoder (LOCK_COUNT=8, SEARCH_LEN=64).
module tb_tmds_decoder;

   logic       pixclk = 1'b0;
   logic       reset  = 1'b0;
   logic       resync = 1'b0;
   logic [9:0] raw_in = 10'h3FF;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic       DE;
   logic       locked;
   logic [3:0] offset;
`ifdef TMDS_DEC_SLIP_STATS_EN
   logic [15:0] slip_count;
   logic        lock_lost;
`endif

   always #5 pixclk = ~pixclk;

   tmds_decoder #(.LOCK_COUNT(8), .SEARCH_LEN(64)) dut (
      .pixclk (pixclk),
      .reset  (reset),
      .raw_in (raw_in),
      .resync (resync),
      .data   (data),
      .ctrl   (ctrl),
      .DE     (DE),
      .locked (locked),
      .offset (offset)
`ifdef TMDS_DEC_SLIP_STATS_EN
      ,
      .slip_count (slip_count),
      .lock_lost  (lock_lost)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;

   // Source stream state: words are delivered delayed by 'shift' bits
   logic [9:0] src_prev = 10'h000;
   int         shift    = 0;

   // Expected outputs for the two words still in the pipeline
   logic       pc0 = 1'b0, pc1 = 1'b0;
   logic       pde0 = 1'b0, pde1 = 1'b0;
   logic [7:0] pdata0 = 8'h00, pdata1 = 8'h00;
   logic [1:0] pctrl0 = 2'b00, pctrl1 = 2'b00;
   string      ptag0 = "", ptag1 = "";

   int n;
   int lock_step;
   logic seen9;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " data"},   16'(data),   16'h0);
      chk({tag, " ctrl"},   16'(ctrl),   16'h0);
      chk({tag, " DE"},     16'(DE),     16'h0);
      chk({tag, " locked"}, 16'(locked), 16'h0);
      chk({tag, " offset"}, 16'(offset), 16'h0);
   endtask

   task automatic clear_pend();
      pc0 = 1'b0;
      pc1 = 1'b0;
   endtask

   // Drive one source word; outputs for the word sent two steps earlier are checked
   task automatic xfer(input logic [9:0] w, input logic c, input logic e_de,
                       input logic [7:0] e_data, input logic [1:0] e_ctrl, input string tag);
      logic [19:0] pair;
      pair     = {w, src_prev};
      raw_in   = 10'(pair >> (10 - shift));
      src_prev = w;
      @(posedge pixclk);
      #1;
      if (pc0) begin
         chk({ptag0, " DE"},   16'(DE),   16'(pde0));
         chk({ptag0, " data"}, 16'(data), 16'(pdata0));
         chk({ptag0, " ctrl"}, 16'(ctrl), 16'(pctrl0));
      end
      pc0 = pc1; pde0 = pde1; pdata0 = pdata1; pctrl0 = pctrl1; ptag0 = ptag1;
      pc1 = c;   pde1 = e_de; pdata1 = e_data; pctrl1 = e_ctrl; ptag1 = tag;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge pixclk);
      #1;
      reset = 1'b0;
      clear_pend();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with all-ones input
      #1;
      reset  = 1'b1;
      raw_in = 10'h3FF;
      #1;
      chk_zero("rst_async");
      for (int i = 0; i < 3; i++) begin
         @(posedge pixclk);
         #1;
         chk_zero("rst_hold");
      end
      reset = 1'b0;
      xfer(10'h3FF, 1'b1, 1'b0, 8'h00, 2'b00, "post_rst");
      chk_zero("post_rst_state");

      // Aligned lock and decode
      for (int i = 0; i < 10; i++) xfer(10'h354, 1'b1, 1'b0, 8'h00, 2'b00, "lock_tok");
      chk("aligned_locked", 16'(locked), 16'h1);
      chk("aligned_offset", 16'(offset), 16'h0);
      xfer(10'h067, 1'b1, 1'b1, 8'h57, 2'b00, "d067");
      xfer(10'h298, 1'b1, 1'b1, 8'h57, 2'b00, "d298");
      xfer(10'h154, 1'b1, 1'b0, 8'h00, 2'b10, "t154");
      xfer(10'h1F0, 1'b1, 1'b1, 8'h10, 2'b10, "d1F0");
      xfer(10'h2AB, 1'b1, 1'b0, 8'h00, 2'b11, "t2AB");
      xfer(10'h2AA, 1'b1, 1'b1, 8'h01, 2'b11, "d2AA");
      xfer(10'h0AB, 1'b1, 1'b0, 8'h00, 2'b01, "t0AB");
      for (int i = 0; i < 10; i++) xfer(10'h354, 1'b1, 1'b0, 8'h00, 2'b00, "requal_tok");
      chk("requal_locked", 16'(locked), 16'h1);

      // Loss of lock through a long data run
      n = 0;
      for (int i = 1; i <= 80; i++) begin
         xfer(10'h067, (i <= 20), 1'b1, 8'h57, 2'b00, "loss_d");
         n = i;
         if (!locked) break;
      end
      chk("loss_locked", 16'(locked), 16'h0);
      chk("loss_len_ok", 16'(n >= 64 && n <= 70), 16'h1);
      chk("loss_offset", 16'(offset), 16'h1);
`ifdef TMDS_DEC_SLIP_STATS_EN
      chk("lock_lost_pulse", 16'(lock_lost), 16'h1);
      chk("slip_count_loss", slip_count, 16'd1);
`endif
      xfer(10'h354, 1'b0, 1'b0, 8'h00, 2'b00, "wrap_tok");
`ifdef TMDS_DEC_SLIP_STATS_EN
      chk("lock_lost_clear", 16'(lock_lost), 16'h0);
`endif

      // Slip through offset 9 back to 0 and relock on the aligned stream
      seen9 = 1'b0;
      for (int i = 0; i < 700; i++) begin
         xfer(10'h354, 1'b0, 1'b0, 8'h00, 2'b00, "wrap_tok");
         if (offset == 4'd9) seen9 = 1'b1;
         if (locked) break;
      end
      chk("wrap_seen9", 16'(seen9), 16'h1);
      chk("wrap_offset", 16'(offset), 16'h0);
      chk("wrap_locked", 16'(locked), 16'h1);
`ifdef TMDS_DEC_SLIP_STATS_EN
      chk("slip_count_wrap", slip_count, 16'd10);
`endif

      // Resync while locked: unlock next cycle, offset kept, outputs forced idle
      xfer(10'h2AB, 1'b1, 1'b0, 8'h00, 2'b11, "rs_t2AB_a");
      xfer(10'h2AB, 1'b1, 1'b0, 8'h00, 2'b11, "rs_t2AB_b");
      xfer(10'h2AB, 1'b1, 1'b0, 8'h00, 2'b00, "rs_t2AB_c");
      resync = 1'b1;
      xfer(10'h067, 1'b1, 1'b0, 8'h00, 2'b00, "rs_d067");
      resync = 1'b0;
      chk("resync_locked", 16'(locked), 16'h0);
      chk("resync_offset", 16'(offset), 16'h0);
`ifdef TMDS_DEC_SLIP_STATS_EN
      chk("slip_count_resync", slip_count, 16'd10);
`endif
      for (int i = 0; i < 11; i++) xfer(10'h354, 1'b1, 1'b0, 8'h00, 2'b00, "relock_tok");
      chk("relock_locked", 16'(locked), 16'h1);

      // Stream delayed by 3 bits
      pulse_reset();
      shift     = 3;
      lock_step = 0;
      for (int i = 1; i <= 210; i++) begin
         xfer(10'h354, 1'b0, 1'b0, 8'h00, 2'b00, "mis_tok");
         if (i == 32)  chk("mis_off0", 16'(offset), 16'h0);
         if (i == 96)  chk("mis_off1", 16'(offset), 16'h1);
         if (i == 160) chk("mis_off2", 16'(offset), 16'h2);
         if (locked) begin
            lock_step = i;
            break;
         end
      end
      chk("mis_lock_in_time", 16'(lock_step > 0 && lock_step <= 203), 16'h1);
      chk("mis_offset", 16'(offset), 16'h3);
`ifdef TMDS_DEC_SLIP_STATS_EN
      chk("slip_count_mis", slip_count, 16'd3);
`endif
      xfer(10'h1F0, 1'b1, 1'b1, 8'h10, 2'b00, "mis_d1F0");
      xfer(10'h067, 1'b1, 1'b1, 8'h57, 2'b00, "mis_d067");
      xfer(10'h154, 1'b1, 1'b0, 8'h00, 2'b10, "mis_t154");
      xfer(10'h154, 1'b1, 1'b0, 8'h00, 2'b10, "mis_t154b");
      xfer(10'h154, 1'b1, 1'b0, 8'h00, 2'b10, "mis_t154c");
      xfer(10'h154, 1'b0, 1'b0, 8'h00, 2'b10, "mis_flush");
      xfer(10'h154, 1'b0, 1'b0, 8'h00, 2'b10, "mis_flush");

      // Lock at offset 5, then reset in the middle of a data period
      pulse_reset();
      shift     = 5;
      lock_step = 0;
      for (int i = 1; i <= 345; i++) begin
         xfer(10'h354, 1'b0, 1'b0, 8'h00, 2'b00, "o5_tok");
         if (locked) begin
            lock_step = i;
            break;
         end
      end
      chk("o5_lock_in_time", 16'(lock_step > 0 && lock_step <= 331), 16'h1);
      chk("o5_offset", 16'(offset), 16'h5);
      xfer(10'h067, 1'b1, 1'b1, 8'h57, 2'b00, "o5_d067");
      xfer(10'h067, 1'b0, 1'b1, 8'h57, 2'b00, "o5_d067b");
      xfer(10'h067, 1'b0, 1'b1, 8'h57, 2'b00, "o5_d067c");
      #2;
      reset = 1'b1;
      #1;
      chk_zero("mid_rst");
      @(posedge pixclk);
      #1;
      reset = 1'b0;
      clear_pend();
      shift = 0;
      for (int i = 0; i < 12; i++) xfer(10'h354, 1'b1, 1'b0, 8'h00, 2'b00, "post_mid_tok");
      chk("post_mid_locked", 16'(locked), 16'h1);
      chk("post_mid_offset", 16'(offset), 16'h0);
`ifdef TMDS_DEC_SLIP_STATS_EN
      chk("slip_count_post_mid", slip_count, 16'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
